chase_counter: RTL and testbench

//   Free-running/steppable frame counter that drives the HEX chase-animation decoder.

---
 rtl/chase_counter_pkg.sv | 21 ++
 rtl/chase_counter_key.sv | 61 ++++++
 rtl/chase_counter.sv | 130 +++++++++++++
 tb/tb_chase_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_counter_pkg.sv
// Shared definitions for the HEX chase-animation frame counter: run/stop state
// encoding, prescaler divide-ratio derivation and a counter-width helper.
package chase_counter_pkg;

  // Run/stop state of the frame counter.
  typedef enum logic {
    StStop = 1'b0,
    StRun  = 1'b1
  } run_state_e;

  // Bits needed for a counter that walks 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Clock cycles per animation tick. Callers must keep the result >= 2.
  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/chase_counter_key.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle press pulse on the debounced high->low (press) edge.
module key_conditioner
  import chase_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  // Bring the raw asynchronous key into the clock domain; idle level is high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_ni};
    end
  end

  // Accept a new level only after DEBOUNCE_CYC consecutive samples that
  // disagree with the current one; any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  // Debounce state and the registered press pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/chase_counter.sv
// Frame counter for the HEX chase animation. A prescaler divides CLOCK_50 down
// to the animation rate; pushbuttons toggle run/stop or single-step a frame
// while stopped, and a switch selects the count direction. All outputs come
// straight from flops so the decoder can clock on a count bit.
module chase_counter
  import chase_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 100,
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned STEP_SIZE    = 8,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned AUTO_RUN     = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             run_key,
  input  logic             step_key,
  input  logic             dir,
  output logic [WIDTH-1:0] count_out,
  output logic             tick,
  output logic             running
);

  localparam int unsigned           Div        = div_of(CLK_HZ, TICK_HZ);
  localparam int unsigned           PrescW     = cnt_width(Div);
  localparam logic [PrescW-1:0]     PrescMax   = PrescW'(Div - 1);
  localparam logic [WIDTH-1:0]      StepVal    = WIDTH'(STEP_SIZE);
  localparam logic [WIDTH-1:0]      OneVal     = WIDTH'(1);
  localparam run_state_e            ResetState = (AUTO_RUN != 0) ? StRun : StStop;

  logic             run_press;
  logic             step_press;
  logic [1:0]       dir_sync_q;
  logic             count_down;

  run_state_e       state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  key_conditioner #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_run_key (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .key_ni  (run_key),
    .press_o (run_press)
  );

  key_conditioner #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_step_key (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .key_ni  (step_key),
    .press_o (step_press)
  );

  // Direction switch is only synchronized; a slide switch does not bounce
  // enough to matter and a change simply applies to the next advance.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dir_sync_q <= 2'b00;
    end else begin
      dir_sync_q <= {dir_sync_q[0], dir};
    end
  end

  assign count_down = dir_sync_q[1];

  // Next state: a run press always wins and swallows any same-cycle step or
  // prescaler wrap, so the count never moves on the toggle edge.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (run_press) begin
          state_d = StStop;
        end else if (presc_q == PrescMax) begin
          presc_d = '0;
          count_d = count_down ? (count_q - OneVal) : (count_q + OneVal);
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + PrescW'(1);
        end
      end
      StStop: begin
        if (run_press) begin
          state_d = StRun;
          presc_d = '0;
        end else if (step_press) begin
          count_d = count_down ? (count_q - StepVal) : (count_q + StepVal);
          tick_d  = 1'b1;
        end
      end
      default: begin
        state_d = ResetState;
        presc_d = '0;
      end
    endcase
    running_d = (state_d == StRun);
  end

  // State, prescaler, count and registered status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ResetState;
      presc_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= (ResetState == StRun);
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign count_out = count_q;
  assign tick      = tick_q;
  assign running   = running_q;

endmodule

// File: tb/tb_chase_counter.sv
// Randomized scoreboard bench for chase_counter with small sim parameters.
module tb_chase_counter;

  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned TickHz  = 100;
  localparam int unsigned Div     = 10;
  localparam int unsigned Width   = 10;
  localparam int unsigned Step    = 8;
  localparam int unsigned Deb     = 4;
  localparam int          Modulus = 1 << Width;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_key;
  logic             step_key;
  logic             dir;
  logic [Width-1:0] count_out;
  logic             tick;
  logic             running;

  chase_counter #(
    .CLK_HZ       (ClkHz),
    .TICK_HZ      (TickHz),
    .WIDTH        (Width),
    .STEP_SIZE    (Step),
    .DEBOUNCE_CYC (Deb),
    .AUTO_RUN     (1)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .run_key   (run_key),
    .step_key  (step_key),
    .dir       (dir),
    .count_out (count_out),
    .tick      (tick),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state.
  int           cyc_m   = 0;
  int           m_count = 0;
  bit           m_run   = 1'b1;
  int           m_phase = 0;     // cycles spent running since the last tick or entry
  bit [Deb+2:0] run_h   = '1;    // raw samples, bit j = sample j edges ago
  bit [Deb+2:0] step_h  = '1;
  bit [1:0]     dir_h   = '0;
  bit           run_lvl = 1'b1;
  bit           step_lvl = 1'b1;

  task automatic report(input string name, input int got, input int exp);
    miscompares++;
    $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_m, got, exp);
  endtask

  // A key's accepted level flips once its DEB oldest samples (seen through the
  // two-stage synchronizer) all disagree with it.
  function automatic bit next_level(input bit [Deb+2:0] h, input bit lvl);
    bit [Deb-1:0] win;
    win = h[Deb+2:3];
    if (lvl && (win == '0)) return 1'b0;
    if (!lvl && (&win)) return 1'b1;
    return lvl;
  endfunction

  function automatic void advance(input int delta);
    exp_t e;
    m_count = (m_count + delta + Modulus) % Modulus;
    e.cyc = cyc_m;
    e.val = m_count;
    sb_q.push_back(e);
  endfunction

  // Behavioural model, evaluated on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    bit rp, sp, nl, up;
    cyc_m++;
    if (rst) begin
      run_h    = '1;
      step_h   = '1;
      dir_h    = '0;
      run_lvl  = 1'b1;
      step_lvl = 1'b1;
      m_count  = 0;
      m_run    = 1'b1;
      m_phase  = 0;
    end else begin
      run_h    = {run_h[Deb+1:0], run_key};
      step_h   = {step_h[Deb+1:0], step_key};
      nl       = next_level(run_h, run_lvl);
      rp       = run_lvl & ~nl;
      run_lvl  = nl;
      nl       = next_level(step_h, step_lvl);
      sp       = step_lvl & ~nl;
      step_lvl = nl;
      up       = ~dir_h[1];
      dir_h    = {dir_h[0], dir};
      if (rp) begin
        m_run = ~m_run;
        if (m_run) m_phase = 0;
      end else if (m_run) begin
        m_phase++;
        if (m_phase == int'(Div)) begin
          m_phase = 0;
          advance(up ? 1 : -1);
        end
      end else if (sp) begin
        advance(up ? int'(Step) : -int'(Step));
      end
    end
  end

  // Monitor: per-cycle status check plus scoreboard pop on every tick.
  always @(negedge clk) begin
    exp_t e;
    if (cyc_m > 0) begin
      vectors++;
      if (running !== m_run) report("running", int'(running), int'(m_run));
      vectors++;
      if (count_out !== Width'(m_count)) report("count_out", int'(count_out), m_count);
      if (tick === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          report("tick_unexpected", int'(count_out), -1);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != cyc_m) report("tick_cycle", cyc_m, e.cyc);
          else if (count_out !== Width'(e.val)) report("tick_value", int'(count_out), e.val);
        end
      end else if (tick !== 1'b0) begin
        vectors++;
        report("tick_unknown", -1, 0);
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc_m) begin
        vectors++;
        e = sb_q.pop_front();
        report("tick_missing", 0, e.val);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit do_run, input bit do_step, input int len, input int gap);
    if (do_run) run_key = 1'b0;
    if (do_step) step_key = 1'b0;
    cycles(len);
    run_key  = 1'b1;
    step_key = 1'b1;
    cycles(gap);
  endtask

  task automatic wait_count(input int v, input string name);
    int n = 0;
    while (m_count != v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (m_count != v) begin
      vectors++;
      report(name, m_count, v);
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (!(m_run && m_phase == p) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(m_run && m_phase == p)) begin
      vectors++;
      report("wait_phase", m_phase, p);
    end
  endtask

  initial begin
    rst      = 1'b1;
    run_key  = 1'b1;
    step_key = 1'b1;
    dir      = 1'b0;
    cycles(3);
    rst = 1'b0;

    // Free run from reset: ticks at 10 and 20 cycles.
    cycles(25);

    // Down through zero to 1023, then back up across the wrap.
    dir = 1'b1;
    wait_count(1023, "reach_1023");
    dir = 1'b0;
    wait_count(0, "reach_0");

    // Stop, hold frozen, restart.
    press(1'b1, 1'b0, 6, 8);
    cycles(100);
    press(1'b1, 1'b0, 6, 8);
    cycles(25);

    // Stop at 1020 and step across the top.
    dir = 1'b1;
    wait_count(1020, "reach_1020");
    press(1'b1, 1'b0, 6, 8);
    dir = 1'b0;
    cycles(3);
    press(1'b0, 1'b1, 6, 8);
    press(1'b1, 1'b0, 6, 8);
    press(1'b0, 1'b1, 6, 8);
    cycles(20);

    // Glitchy run key never toggles; then simultaneous run+step while stopped.
    for (int i = 0; i < 12; i++) begin
      run_key = 1'b0;
      cycles(int'($urandom_range(1, 3)));
      run_key = 1'b1;
      cycles(int'($urandom_range(1, 3)));
    end
    cycles(10);
    press(1'b1, 1'b0, 6, 8);
    press(1'b1, 1'b1, 6, 8);
    cycles(15);

    // Reset mid-period and during a debounce window.
    wait_phase(7);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(5);
    run_key = 1'b0;
    cycles(3);
    rst     = 1'b1;
    run_key = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(30);

    // Random mix of everything.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: cycles(int'($urandom_range(1, 25)));
        1: press(1'b1, 1'b0, int'($urandom_range(1, 7)), int'($urandom_range(1, 8)));
        2: press(1'b0, 1'b1, int'($urandom_range(1, 7)), int'($urandom_range(1, 8)));
        3: begin
          dir = 1'($urandom_range(0, 1));
          cycles(int'($urandom_range(1, 5)));
        end
        4: press(1'b1, 1'b1, int'($urandom_range(1, 7)), int'($urandom_range(1, 8)));
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            rst = 1'b1;
            cycles(int'($urandom_range(1, 2)));
            rst = 1'b0;
          end
          cycles(3);
        end
      endcase
    end

    run_key  = 1'b1;
    step_key = 1'b1;
    cycles(20);
    vectors++;
    if (sb_q.size() != 0) report("scoreboard_drain", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
